grain_prog_loader: RTL
======================

# grain_prog_loader

Configuration sequencer for the GrainFlex fabric's serial programming interface. Accepts a bitstream as a byte stream over a valid/ready handshake, pulses the fabric's programming reset, and shifts `CHAIN_LEN` bits into the configuration chain by generating `prog_clk`, `prog_en` and `prog_din` from the system clock. Sits between the host-facing pins/loader logic and the GrainFlexFpga `progIface` port. It is the only driver of that port.

## Interface

- `CHAIN_LEN`, 256: configuration chain length in bits. Must be a multiple of 8 and at least 8.
- `CLK_DIV`, 2: `prog_clk` half-period in `clk` cycles. Must be at least 1.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a load session. Sampled only in IDLE.
- `abort` in 1: terminates the session in progress.
- `byte_data` in 8: bitstream byte, shifted LSB first.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `busy` out 1: a session is in progress.
- `done` out 1: one-cycle pulse at session end.
- `err` out 1: sticky error flag. Cleared by the next accepted `start`.
- `crc` out 8: CRC-8 of all bits sent in the last session.
- `prog_clk` out 1: chain shift clock.
- `prog_rst` out 1: chain reset.
- `prog_en` out 1: chain shift enable.
- `prog_din` out 1: chain serial data in.
- `prog_dout` in 1: chain serial data out.

## Operation

- **Reset values:** all outputs are 0, including `crc` = 0x00. The FSM is in IDLE.
- **States:** IDLE → PRST → FETCH ⇄ SHIFT → (VERIFY) → FIN → IDLE.
- **IDLE**
  - `start` = 1 goes to PRST.
  - In the same edge: clears `err` and `crc`, and sets the bit counter to 0.
- **PRST**
  - `prog_rst` = 1 for exactly 4 cycles, then goes to FETCH.
  - `prog_en` = 0 throughout.
- **FETCH**
  - `byte_ready` = 1 and `prog_en` = 1; `prog_clk` is held at 0.
  - `byte_valid && byte_ready` latches `byte_data` into the shift register and goes to SHIFT.
  - `byte_ready` is 0 in every state other than FETCH.
- **SHIFT:** 8 bit periods per byte, each `2*CLK_DIV` cycles long.
  - Low phase (`CLK_DIV` cycles): `prog_din` = current shift-register LSB, `prog_clk` = 0.
  - High phase (`CLK_DIV` cycles): `prog_clk` = 1.
  - The chain samples `prog_din` on the rising edge of `prog_clk`.
  - The CRC is updated with each bit at its rising edge.
  - After bit 7, if total bits < `CHAIN_LEN`, go to FETCH; otherwise go to VERIFY (if compiled in) or FIN.
- **FIN:** `done` = 1 for one cycle, then go to IDLE. `prog_en` drops to 0 entering FIN.
- **CRC:** CRC-8, polynomial 0x07, init 0x00, one bit per step, bits in shift order.
  - `crc` output updates live.
  - After the session, `crc` holds the final value until the next `start`.
- **abort** in any non-IDLE state:
  - Next cycle: IDLE, `busy` = `prog_en` = `prog_clk` = `prog_rst` = `prog_din` = 0, `err` = 1.
  - No `done` pulse.
- **Ignored inputs:**
  - `start` while not in IDLE is ignored.
  - `abort` in IDLE is ignored.
  - `abort` and `start` in the same IDLE cycle: `start` wins.
- **Async reset mid-session:** all outputs go to reset values immediately. A partially loaded chain is not cleaned up; the next session's PRST reset handles it.
- **busy:** 1 in every state except IDLE.

## Timing

- `start` sampled at edge 0.
  - `busy` = 1 and `prog_rst` = 1 from cycle 1.
  - `prog_rst` stays 1 through cycle 4.
  - FETCH begins at cycle 5.
- **Byte acceptance:** takes 1 cycle when `byte_valid` is already high.
- **Per byte:** 1 FETCH cycle + `16*CLK_DIV` SHIFT cycles.
- **Back-to-back load, feature off:** `start` to `done` = 5 + (`CHAIN_LEN`/8)·(1 + `16*CLK_DIV`) cycles. `done` is in the cycle after the last high phase.
- **Backpressure:** stalls in FETCH with `prog_clk` low and `prog_en` high. No extra edges are generated.
- **Rising-edge count:** exactly `CHAIN_LEN` `prog_clk` rising edges per completed session (feature off).

## Configuration

- **Macro:** `GRAIN_PROG_VERIFY_EN`.
- **Defined:** after the last byte, the FSM enters VERIFY.
  - Runs `CHAIN_LEN` additional bit periods with identical timing.
  - `prog_din` = `prog_dout`, sampled in the last cycle of each low phase. The chain contents recirculate unchanged.
  - A second CRC-8 is computed over the sampled bits.
  - At FIN, `err` is set if the verify CRC ≠ the load CRC.
  - Adds `CHAIN_LEN·2·CLK_DIV` cycles to the session.
- **Undefined:** no VERIFY state, no second CRC register, `prog_dout` is unused. `err` is set only by `abort`.

## Test plan

- **Basic load:** `CHAIN_LEN`=16, `CLK_DIV`=1, bytes 0xA5 then 0x3C, `byte_valid` held high → `prog_din` at the 16 rising edges = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. Exactly 16 edges. `done` at cycle 39. `crc` = software CRC-8/0x07 of that stream. `err` = 0.
- **Backpressure:** same as basic load, but `byte_valid` low for 10 cycles between bytes → `prog_clk` stays 0 and `prog_en` stays 1 during the gap. Same `prog_din` sequence. `done` is delayed by 10 cycles.
- **Verify pass/fail:** with `GRAIN_PROG_VERIFY_EN` and a 16-bit shift-register chain model → `err` = 0 and 32 total edges. With the model's `prog_dout` stuck at 0 → `err` = 1 at `done`.
- **Abort mid-byte:** `abort` during bit 3 of byte 0 → next cycle `busy` = `prog_en` = `prog_clk` = 0 and `err` = 1, with no `done`. A subsequent `start` clears `err` and reasserts `prog_rst` for 4 cycles.
- **Async reset mid-shift:** `rst_n` low during a `prog_clk` high phase → all outputs are 0 before the next `clk` edge and stay 0 until `rst_n` rises.
- **start while busy:** `start` pulsed during SHIFT → no PRST re-entry, and the session completes normally.

Source files
------------

// File: rtl/grain_prog_loader.sv
// rtl/grain_prog_loader.sv - serial configuration sequencer for the GrainFlex programming port
//
// Takes a bitstream as bytes over a valid/ready handshake, pulses the chain
// reset, then shifts CHAIN_LEN bits LSB-first into the configuration chain.
// Optional read-back: define GRAIN_PROG_VERIFY_EN to recirculate the chain
// once more and compare a second CRC-8 against the load CRC.
//
// Ports:
//   i_clk, i_rst_n                 system clock, async active-low reset
//   i_start, i_abort               session control
//   i_byte_data/valid, o_byte_ready bitstream byte handshake
//   o_busy, o_done, o_err          session status (err is sticky)
//   o_crc                          CRC-8 (poly 0x07) of bits sent
//   o_prog_clk/rst/en/din          chain drive
//   i_prog_dout                    chain serial out (read-back only)
module grain_prog_loader #(
  parameter int CHAIN_LEN = 256,
  parameter int CLK_DIV   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_byte_data,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [7:0] o_crc,
  output logic       o_prog_clk,
  output logic       o_prog_rst,
  output logic       o_prog_en,
  output logic       o_prog_din,
  input  logic       i_prog_dout
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LP_LEN      = BW'(CHAIN_LEN);
  localparam logic [DW-1:0] LP_DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_FETCH,
    S_SHIFT,
`ifdef GRAIN_PROG_VERIFY_EN
    S_VERIFY,
`endif
    S_FIN
  } state_t;

  state_t          r_state;
  logic [7:0]      r_sr;
  logic [DW-1:0]   r_div;
  logic            r_phase;   // 0 = prog_clk low half, 1 = high half
  logic [2:0]      r_bit;
  logic [BW-1:0]   r_bits;
  logic [1:0]      r_prst;
  logic [7:0]      r_crc;

`ifdef GRAIN_PROG_VERIFY_EN
  logic [7:0]      r_vcrc;
`else
  logic            w_unused_dout;
  assign w_unused_dout = i_prog_dout;
`endif

  assign o_crc = r_crc;

  function automatic logic [7:0] f_crc8_step(input logic [7:0] c, input logic b);
    f_crc8_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_sr         <= 8'h00;
      r_div        <= '0;
      r_phase      <= 1'b0;
      r_bit        <= 3'd0;
      r_bits       <= '0;
      r_prst       <= 2'd0;
      r_crc        <= 8'h00;
`ifdef GRAIN_PROG_VERIFY_EN
      r_vcrc       <= 8'h00;
`endif
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_prog_clk   <= 1'b0;
      o_prog_rst   <= 1'b0;
      o_prog_en    <= 1'b0;
      o_prog_din   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (r_state != S_IDLE && i_abort) begin
        // abort outranks every in-session transition; crc keeps its partial value
        r_state      <= S_IDLE;
        o_byte_ready <= 1'b0;
        o_busy       <= 1'b0;
        o_err        <= 1'b1;
        o_prog_clk   <= 1'b0;
        o_prog_rst   <= 1'b0;
        o_prog_en    <= 1'b0;
        o_prog_din   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state    <= S_PRST;
              r_prst     <= 2'd0;
              r_bits     <= '0;
              r_crc      <= 8'h00;
`ifdef GRAIN_PROG_VERIFY_EN
              r_vcrc     <= 8'h00;
`endif
              o_err      <= 1'b0;
              o_busy     <= 1'b1;
              o_prog_rst <= 1'b1;
            end
          end
          S_PRST: begin
            if (r_prst == 2'd3) begin
              r_state      <= S_FETCH;
              o_prog_rst   <= 1'b0;
              o_prog_en    <= 1'b1;
              o_byte_ready <= 1'b1;
            end else begin
              r_prst <= r_prst + 2'd1;
            end
          end
          S_FETCH: begin
            if (i_byte_valid) begin
              r_state      <= S_SHIFT;
              r_sr         <= i_byte_data;
              r_div        <= '0;
              r_phase      <= 1'b0;
              r_bit        <= 3'd0;
              o_byte_ready <= 1'b0;
              o_prog_din   <= i_byte_data[0];
            end
          end
          S_SHIFT: begin
            if (r_div != LP_DIV_LAST) begin
              r_div <= r_div + 1'b1;
            end else begin
              r_div <= '0;
              if (!r_phase) begin
                // rising edge of prog_clk: the chain and the CRC take the bit together
                r_phase    <= 1'b1;
                o_prog_clk <= 1'b1;
                r_crc      <= f_crc8_step(r_crc, r_sr[0]);
                r_bits     <= r_bits + 1'b1;
              end else begin
                r_phase    <= 1'b0;
                o_prog_clk <= 1'b0;
                if (r_bit != 3'd7) begin
                  r_bit      <= r_bit + 3'd1;
                  r_sr       <= {1'b0, r_sr[7:1]};
                  o_prog_din <= r_sr[1];
                end else if (r_bits != LP_LEN) begin
                  r_state      <= S_FETCH;
                  o_byte_ready <= 1'b1;
                end else begin
`ifdef GRAIN_PROG_VERIFY_EN
                  r_state    <= S_VERIFY;
                  r_bits     <= '0;
                  o_prog_din <= i_prog_dout;
`else
                  r_state    <= S_FIN;
                  o_prog_en  <= 1'b0;
                  o_prog_din <= 1'b0;
                  o_done     <= 1'b1;
`endif
                end
              end
            end
          end
`ifdef GRAIN_PROG_VERIFY_EN
          S_VERIFY: begin
            // dout only moves on a prog_clk rise, so it is stable for the whole
            // low half; din is loaded at low entry, the CRC samples at low exit
            if (r_div != LP_DIV_LAST) begin
              r_div <= r_div + 1'b1;
            end else begin
              r_div <= '0;
              if (!r_phase) begin
                r_phase    <= 1'b1;
                o_prog_clk <= 1'b1;
                r_vcrc     <= f_crc8_step(r_vcrc, i_prog_dout);
                r_bits     <= r_bits + 1'b1;
              end else begin
                r_phase    <= 1'b0;
                o_prog_clk <= 1'b0;
                if (r_bits != LP_LEN) begin
                  o_prog_din <= i_prog_dout;
                end else begin
                  r_state    <= S_FIN;
                  o_prog_en  <= 1'b0;
                  o_prog_din <= 1'b0;
                  o_done     <= 1'b1;
                  o_err      <= (r_vcrc != r_crc);
                end
              end
            end
          end
`endif
          S_FIN: begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
